// File: rtl/frame_capture_writer.sv
// rtl/frame_capture_writer.sv - captures one windowed 1-bit frame from the VGA scan into external RAM
// Write address layout matches the ROM reader: {row offset, column offset}.

module frame_capture_writer #(
    parameter int ROW0       = 0,
    parameter int COL0       = 0,
    parameter int WIN_H_LOG2 = 7,
    parameter int WIN_W_LOG2 = 8,
    parameter int ADDR_W     = WIN_H_LOG2 + WIN_W_LOG2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pix_stb,
    input  logic              video_on,
    input  logic [9:0]        pixel_row,
    input  logic [9:0]        pixel_column,
    input  logic              pix_in,
    input  logic              arm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_data,
    output logic              busy,
    output logic              done,
    output logic              tear
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [9:0]      ROW0_V = ROW0[9:0];
    localparam logic [9:0]      COL0_V = COL0[9:0];
    localparam logic [10:0]     WIN_H  = 11'(1 << WIN_H_LOG2);
    localparam logic [10:0]     WIN_W  = 11'(1 << WIN_W_LOG2);
    localparam logic [ADDR_W:0] LAST   = (ADDR_W+1)'((1 << ADDR_W) - 1);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                tear_q, tear_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [9:0]          row_off, col_off;
    logic                in_win, hit, sof, do_write;
    logic [ADDR_W-1:0]   pix_addr;

    assign row_off  = pixel_row - ROW0_V;
    assign col_off  = pixel_column - COL0_V;
    assign in_win   = (pixel_row >= ROW0_V) && ({1'b0, row_off} < WIN_H) &&
                      (pixel_column >= COL0_V) && ({1'b0, col_off} < WIN_W);
    assign hit      = pix_stb & video_on & in_win;
    assign sof      = pix_stb & video_on & (pixel_row == ROW0_V) & (pixel_column == COL0_V);
    assign pix_addr = {row_off[WIN_H_LOG2-1:0], col_off[WIN_W_LOG2-1:0]};

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        tear_d    = tear_q;
        do_write  = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = ARMED;
                    tear_d  = 1'b0;
                    count_d = '0;
                end
            end
            ARMED: begin
                if (sof) begin
                    state_d  = CAPTURE;
                    do_write = 1'b1;
                    count_d  = (ADDR_W+1)'(1);
                end
            end
            CAPTURE: begin
                if (hit) begin
                    do_write = 1'b1;
                    if (sof && count_q != '0) begin
                        // Frame restarted under us: flag it and start the window over.
                        tear_d  = 1'b1;
                        count_d = (ADDR_W+1)'(1);
                    end else begin
                        count_d = count_q + 1'b1;
                        // count_q already holds the writes so far; this hit is the last address.
                        if (count_q == LAST) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_write) begin
            wr_en_d   = 1'b1;
            wr_addr_d = pix_addr;
            wr_data_d = pix_in;
        end

        busy_d = (state_d == ARMED) || (state_d == CAPTURE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            tear_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            tear_q    <= tear_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign tear    = tear_q;

endmodule

// File: tb/tb_frame_capture_writer.sv
// tb/tb_frame_capture_writer.sv - directed self-checking bench for frame_capture_writer
// Scans a compact raster (rows 0..128, cols 0..257) one pixel per clock.

module tb_frame_capture_writer;

    logic        clock;
    logic        reset;
    logic        pix_stb;
    logic        video_on;
    logic [9:0]  pixel_row;
    logic [9:0]  pixel_column;
    logic        pix_in;
    logic        arm;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic        wr_data;
    logic        busy;
    logic        done;
    logic        tear;

    int tests_run;
    int tests_failed;

    int          trk_writes;
    int          trk_err;
    int          trk_done;
    logic [14:0] trk_exp;
    logic [14:0] trk_bad_addr;

    frame_capture_writer dut (
        .clock        (clock),
        .reset        (reset),
        .pix_stb      (pix_stb),
        .video_on     (video_on),
        .pixel_row    (pixel_row),
        .pixel_column (pixel_column),
        .pix_in       (pix_in),
        .arm          (arm),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .tear         (tear)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic reset_trk();
        trk_writes   = 0;
        trk_err      = 0;
        trk_done     = 0;
        trk_exp      = 15'd0;
        trk_bad_addr = 15'd0;
    endtask

    // Advance one clock and sample #1 later; writes must arrive in address order with data = addr[0].
    task automatic step();
        @(posedge clock);
        #1;
        if (wr_en === 1'b1) begin
            if (wr_addr !== trk_exp || wr_data !== trk_exp[0]) begin
                if (trk_err == 0) trk_bad_addr = wr_addr;
                trk_err++;
            end
            trk_exp = trk_exp + 15'd1;
            trk_writes++;
        end
        if (done === 1'b1) begin
            trk_done++;
            if (!(wr_en === 1'b1 && wr_addr === 15'h7fff)) trk_err++;
        end
    endtask

    task automatic px(input logic [9:0] r, input logic [9:0] c, input logic von,
                      input logic stb, input logic pin, input logic a);
        pixel_row    = r;
        pixel_column = c;
        video_on     = von;
        pix_stb      = stb;
        pix_in       = pin;
        arm          = a;
        step();
        arm     = 1'b0;
        pix_stb = 1'b0;
    endtask

    task automatic scan(input int r0, input int c0, input int r1, input int arm_row,
                        input int stop_after);
        for (int r = r0; r <= r1; r++) begin
            for (int c = (r == r0) ? c0 : 0; c <= 257; c++) begin
                px(r[9:0], c[9:0], (c < 257), 1'b1, c[0], (r == arm_row && c == 0));
                if (stop_after != 0 && trk_writes >= stop_after) return;
            end
        end
    endtask

    task automatic arm_pulse();
        px(10'd300, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        tests_run++;
        if ({wr_en, wr_addr, wr_data, busy, done, tear} !== 20'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h want 0", {wr_en, wr_addr, wr_data, busy, done, tear});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_no_arm();
        reset_trk();
        scan(0, 0, 3, -1, 0);
        tests_run++;
        if (trk_writes !== 0) begin
            tests_failed++;
            $display("FAIL no_arm_writes: got %0d want 0", trk_writes);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_arm_busy: got %b want 0", busy);
        end
        tests_run++;
        if (trk_done !== 0) begin
            tests_failed++;
            $display("FAIL no_arm_done: got %0d want 0", trk_done);
        end
    endtask

    task automatic test_latency();
        arm_pulse();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL lat_busy_armed: got %b want 1", busy);
        end
        px(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (wr_en !== 1'b1 || wr_addr !== 15'h0000) begin
            tests_failed++;
            $display("FAIL lat_sof_write: got en=%b addr=%h want en=1 addr=0000", wr_en, wr_addr);
        end
        px(10'd5, 10'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        tests_run++;
        if (wr_en !== 1'b1 || wr_addr !== 15'h0503 || wr_data !== 1'b1) begin
            tests_failed++;
            $display("FAIL lat_hit: got en=%b addr=%h data=%b want en=1 addr=0503 data=1",
                     wr_en, wr_addr, wr_data);
        end
        px(10'd5, 10'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (wr_en !== 1'b0 || wr_addr !== 15'h0503 || wr_data !== 1'b1) begin
            tests_failed++;
            $display("FAIL lat_hold: got en=%b addr=%h data=%b want en=0 addr=0503 data=1",
                     wr_en, wr_addr, wr_data);
        end
        px(10'd5, 10'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (wr_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL lat_no_stb: got en=%b want 0", wr_en);
        end
        px(10'd5, 10'd300, 1'b1, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (wr_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL lat_col_outside: got en=%b want 0", wr_en);
        end
        px(10'd130, 10'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (wr_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL lat_row_outside: got en=%b want 0", wr_en);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_arm_mid_frame();
        reset_trk();
        scan(126, 0, 128, 127, 0);
        tests_run++;
        if (trk_writes !== 0) begin
            tests_failed++;
            $display("FAIL mid_arm_early_writes: got %0d want 0", trk_writes);
        end
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_arm_busy: got %b want 1", busy);
        end
        scan(0, 0, 128, -1, 0);
        tests_run++;
        if (trk_writes !== 32768) begin
            tests_failed++;
            $display("FAIL frame_write_count: got %0d want 32768", trk_writes);
        end
        tests_run++;
        if (trk_err !== 0) begin
            tests_failed++;
            $display("FAIL frame_order: got %0d bad writes (first addr %h) want 0", trk_err, trk_bad_addr);
        end
        tests_run++;
        if (trk_done !== 1) begin
            tests_failed++;
            $display("FAIL frame_done_pulses: got %0d want 1", trk_done);
        end
        tests_run++;
        if (tear !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL frame_end_flags: got tear=%b busy=%b want 0 0", tear, busy);
        end
    endtask

    task automatic test_tear();
        arm_pulse();
        reset_trk();
        scan(0, 0, 128, -1, 1000);
        tests_run++;
        if (trk_writes !== 1000 || trk_err !== 0 || tear !== 1'b0) begin
            tests_failed++;
            $display("FAIL tear_pre: got writes=%0d err=%0d tear=%b want 1000 0 0", trk_writes, trk_err, tear);
        end
        reset_trk();
        px(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (wr_en !== 1'b1 || wr_addr !== 15'h0000) begin
            tests_failed++;
            $display("FAIL tear_restart_addr: got en=%b addr=%h want en=1 addr=0000", wr_en, wr_addr);
        end
        tests_run++;
        if (tear !== 1'b1) begin
            tests_failed++;
            $display("FAIL tear_flag: got %b want 1", tear);
        end
        scan(0, 1, 128, -1, 0);
        tests_run++;
        if (trk_writes !== 32768 || trk_err !== 0) begin
            tests_failed++;
            $display("FAIL tear_rest: got writes=%0d err=%0d want 32768 0", trk_writes, trk_err);
        end
        tests_run++;
        if (trk_done !== 1 || tear !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL tear_end: got done=%0d tear=%b busy=%b want 1 1 0", trk_done, tear, busy);
        end
    endtask

    task automatic test_reset_mid_capture();
        arm_pulse();
        tests_run++;
        if (tear !== 1'b0) begin
            tests_failed++;
            $display("FAIL rearm_tear_clear: got %b want 0", tear);
        end
        reset_trk();
        scan(0, 0, 128, -1, 500);
        reset = 1'b1;
        #1;
        tests_run++;
        if ({wr_en, wr_addr, wr_data, busy, done, tear} !== 20'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: got %h want 0", {wr_en, wr_addr, wr_data, busy, done, tear});
        end
        step();
        reset = 1'b0;
        step();
        tests_run++;
        if (trk_done !== 0) begin
            tests_failed++;
            $display("FAIL mid_reset_done: got %0d want 0", trk_done);
        end
        arm_pulse();
        reset_trk();
        scan(0, 0, 128, -1, 300);
        tests_run++;
        if (trk_writes !== 300 || trk_err !== 0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_capture: got writes=%0d err=%0d busy=%b want 300 0 1",
                     trk_writes, trk_err, busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        pix_stb      = 1'b0;
        video_on     = 1'b0;
        pixel_row    = 10'd0;
        pixel_column = 10'd0;
        pix_in       = 1'b0;
        arm          = 1'b0;
        reset_trk();

        test_reset();
        test_no_arm();
        test_latency();
        test_arm_mid_frame();
        test_tear();
        test_reset_mid_capture();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
